// File: rtl/btn_cursor_ctrl.sv
// btn_cursor_ctrl: five-button front end (sync, debounce, press detect) driving
// an X/Y cursor on a COLS x ROWS grid with edge saturation or wrap, plus a
// centre-button select strobe.
// Optional feature macro: AUTO_REPEAT_EN (held directions auto-repeat).
module btn_cursor_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned COLS            = 8,
  parameter int unsigned ROWS            = 4,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bC,
  input  logic                      bL,
  input  logic                      bU,
  input  logic                      bR,
  input  logic                      bD,
  output logic [$clog2(COLS)-1:0]   cur_x,
  output logic [$clog2(ROWS)-1:0]   cur_y,
  output logic                      moved,
  output logic                      sel,
  output logic [4:0]                btn_db
);

  localparam int unsigned XW = $clog2(COLS);
  localparam int unsigned YW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NB = 5;

  // Bit positions within {bC,bL,bU,bR,bD}
  localparam int unsigned BC = 4;
  localparam int unsigned BL = 3;
  localparam int unsigned BU = 2;
  localparam int unsigned BR = 1;
  localparam int unsigned BD = 0;

  // Elaboration-time sanity check of the configuration
  if (DEBOUNCE_CYCLES < 1 || COLS < 2 || ROWS < 2 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("btn_cursor_ctrl: illegal parameter combination");
  end

  logic [NB-1:0] raw_c;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] db_prev;
  logic [CW-1:0] cnt [NB];
  logic [NB-1:0] press_c;
  logic [3:0]    rep_c;
  logic [3:0]    step_c;
  logic [XW-1:0] nx_c;
  logic [YW-1:0] ny_c;

  assign raw_c   = {bC, bL, bU, bR, bD};
  assign press_c = btn_db & ~db_prev;
  assign step_c  = press_c[3:0] | rep_c;

  // Two-flop synchroniser and per-button debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      btn_db  <= '0;
      db_prev <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      s1      <= raw_c;
      s2      <= s1;
      db_prev <= btn_db;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] != btn_db[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db[i] <= s2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic [TW-1:0] rtmr [4];
  logic [3:0]    rphase;

  // Repeat fires after REPEAT_DELAY cycles of hold, then every REPEAT_RATE cycles
  always_comb begin
    rep_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_db[i] && !press_c[i]) begin
        rep_c[i] = rphase[i] ? (rtmr[i] == TW'(REPEAT_RATE - 1))
                             : (rtmr[i] == TW'(REPEAT_DELAY - 1));
      end
    end
  end

  // Per-direction repeat timers, restarted by each press and cleared on release
  always_ff @(posedge clk) begin
    if (rst) begin
      rphase <= '0;
      for (int i = 0; i < 4; i++) rtmr[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press_c[i] || !btn_db[i]) begin
          rtmr[i]   <= '0;
          rphase[i] <= 1'b0;
        end else if (rep_c[i]) begin
          rtmr[i]   <= '0;
          rphase[i] <= 1'b1;
        end else begin
          rtmr[i] <= rtmr[i] + TW'(1);
        end
      end
    end
  end
`else
  assign rep_c = '0;
`endif

  // Next cursor position; opposing steps on one axis cancel
  always_comb begin
    nx_c = cur_x;
    ny_c = cur_y;
    if (step_c[BL] && !step_c[BR]) begin
      if (cur_x == '0) nx_c = (WRAP != 0) ? XW'(COLS - 1) : cur_x;
      else             nx_c = cur_x - XW'(1);
    end else if (step_c[BR] && !step_c[BL]) begin
      if (cur_x == XW'(COLS - 1)) nx_c = (WRAP != 0) ? '0 : cur_x;
      else                        nx_c = cur_x + XW'(1);
    end
    if (step_c[BU] && !step_c[BD]) begin
      if (cur_y == '0) ny_c = (WRAP != 0) ? YW'(ROWS - 1) : cur_y;
      else             ny_c = cur_y - YW'(1);
    end else if (step_c[BD] && !step_c[BU]) begin
      if (cur_y == YW'(ROWS - 1)) ny_c = (WRAP != 0) ? '0 : cur_y;
      else                        ny_c = cur_y + YW'(1);
    end
  end

  // Registered cursor, move pulse and select strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x <= '0;
      cur_y <= '0;
      moved <= 1'b0;
      sel   <= 1'b0;
    end else begin
      cur_x <= nx_c;
      cur_y <= ny_c;
      moved <= (nx_c != cur_x) || (ny_c != cur_y);
      sel   <= press_c[BC];
    end
  end

endmodule

// File: tb/tb_btn_cursor_ctrl.sv
// Directed bench for btn_cursor_ctrl: three instances share the buttons
// (a: 8x4 saturating, b: 8x4 wrapping, c: 5x3 wrapping).
module tb_btn_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btns;  // {C,L,U,R,D}

  logic [2:0] xa, xb, xc;
  logic [1:0] ya, yb, yc;
  logic       mva, mvb, mvc, sela, selb, selc;
  logic [4:0] dba, dbb, dbc;

  int checks = 0;
  int errors = 0;
  int mv_a = 0, mv_b = 0, mv_c = 0, sel_a = 0;
  int m0, m1, s0;

  localparam logic [4:0] K_C = 5'b10000;
  localparam logic [4:0] K_L = 5'b01000;
  localparam logic [4:0] K_U = 5'b00100;
  localparam logic [4:0] K_R = 5'b00010;
  localparam logic [4:0] K_D = 5'b00001;

  always #5 clk = ~clk;

  btn_cursor_ctrl #(.DEBOUNCE_CYCLES(16), .COLS(8), .ROWS(4), .WRAP(0),
                    .REPEAT_DELAY(64), .REPEAT_RATE(16)) u_a (
    .clk(clk), .rst(rst), .bC(btns[4]), .bL(btns[3]), .bU(btns[2]), .bR(btns[1]),
    .bD(btns[0]), .cur_x(xa), .cur_y(ya), .moved(mva), .sel(sela), .btn_db(dba));

  btn_cursor_ctrl #(.DEBOUNCE_CYCLES(16), .COLS(8), .ROWS(4), .WRAP(1),
                    .REPEAT_DELAY(64), .REPEAT_RATE(16)) u_b (
    .clk(clk), .rst(rst), .bC(btns[4]), .bL(btns[3]), .bU(btns[2]), .bR(btns[1]),
    .bD(btns[0]), .cur_x(xb), .cur_y(yb), .moved(mvb), .sel(selb), .btn_db(dbb));

  btn_cursor_ctrl #(.DEBOUNCE_CYCLES(16), .COLS(5), .ROWS(3), .WRAP(1),
                    .REPEAT_DELAY(64), .REPEAT_RATE(16)) u_c (
    .clk(clk), .rst(rst), .bC(btns[4]), .bL(btns[3]), .bU(btns[2]), .bR(btns[1]),
    .bD(btns[0]), .cur_x(xc), .cur_y(yc), .moved(mvc), .sel(selc), .btn_db(dbc));

  // Count cycles each pulse output is high
  always @(posedge clk) begin
    if (mva === 1'b1)  mv_a++;
    if (mvb === 1'b1)  mv_b++;
    if (mvc === 1'b1)  mv_c++;
    if (sela === 1'b1) sel_a++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
  endtask

  // Called at a negedge; holds mask for 'on' cycles then releases for 'off'
  task automatic press_btn(input logic [4:0] m, input int on, input int off);
    btns = m;
    repeat (on) @(negedge clk);
    btns = '0;
    repeat (off) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    btns = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_x", 32'(xa), 0);
    chk("rst_y", 32'(ya), 0);
    chk("rst_moved", 32'(mva), 0);
    chk("rst_sel", 32'(sela), 0);
    chk("rst_db", 32'(dba), 0);
    chk("rst_xb", 32'(xb), 0);

    // Press latency: update on posedge 19 after first sample
    btns = K_D;
    repeat (18) @(negedge clk);
    chk("lat_y_before", 32'(ya), 0);
    @(negedge clk);
    chk("lat_y_after", 32'(ya), 1);
    chk("lat_moved", 32'(mva), 1);
    chk("lat_db", 32'(dba), 32'(K_D));
    @(negedge clk);
    chk("lat_moved_pulse", 32'(mva), 0);
    repeat (20) @(negedge clk);
    btns = '0;
    repeat (40) @(negedge clk);
    chk("lat_moved_cnt", 32'(mv_a), 1);
    chk("lat_yb", 32'(yb), 1);
    chk("lat_yc", 32'(yc), 1);

    // Right presses: saturation on a, wrap on b and c
    for (int i = 0; i < 5; i++) press_btn(K_R, 40, 40);
    chk("r5_xa", 32'(xa), 5);
    chk("r5_xb", 32'(xb), 5);
    chk("r5_xc", 32'(xc), 0);
    m0 = mv_a;
    for (int i = 0; i < 7; i++) press_btn(K_R, 40, 40);
    chk("r12_xa", 32'(xa), 7);
    chk("r12_moves_a", 32'(mv_a - m0), 2);
    chk("r12_xb", 32'(xb), 4);
    chk("r12_xc", 32'(xc), 2);
    m0 = mv_a;
    for (int i = 0; i < 10; i++) press_btn(K_U, 40, 40);
    chk("u10_ya", 32'(ya), 0);
    chk("u10_moves_a", 32'(mv_a - m0), 1);
    chk("u10_yb", 32'(yb), 3);
    chk("u10_yc", 32'(yc), 0);

    // Left presses across the x=0 edge
    for (int i = 0; i < 4; i++) press_btn(K_L, 40, 40);
    chk("l4_xa", 32'(xa), 3);
    chk("l4_xb", 32'(xb), 0);
    chk("l4_xc", 32'(xc), 3);
    m1 = mv_b;
    press_btn(K_L, 40, 40);
    chk("lwrap_xb", 32'(xb), 7);
    chk("lwrap_moves_b", 32'(mv_b - m1), 1);
    for (int i = 0; i < 2; i++) press_btn(K_L, 40, 40);
    m0 = mv_a;
    press_btn(K_L, 40, 40);
    chk("lsat_xa", 32'(xa), 0);
    chk("lsat_moves_a", 32'(mv_a - m0), 0);
    chk("lwrap_xb2", 32'(xb), 4);
    chk("lwrap_xc", 32'(xc), 4);

    // Down presses across the bottom edge
    press_btn(K_D, 40, 40);
    chk("d1_ya", 32'(ya), 1);
    chk("dwrap_yb", 32'(yb), 0);
    chk("d1_yc", 32'(yc), 1);
    for (int i = 0; i < 3; i++) press_btn(K_D, 40, 40);
    chk("dsat_ya", 32'(ya), 3);
    chk("d4_yb", 32'(yb), 3);
    chk("dwrap_yc", 32'(yc), 1);

    // Short glitch, opposing presses, select
    m0 = mv_a;
    m1 = mv_b;
    press_btn(K_U, 5, 30);
    chk("glitch_ya", 32'(ya), 3);
    chk("glitch_db", 32'(dba), 0);
    press_btn(K_L | K_R, 40, 40);
    chk("lr_xa", 32'(xa), 0);
    chk("lr_xb", 32'(xb), 4);
    chk("lr_xc", 32'(xc), 4);
    chk("lr_moves_b", 32'(mv_b - m1), 0);
    s0 = sel_a;
    press_btn(K_C, 40, 40);
    chk("sel_cnt", 32'(sel_a - s0), 1);
    chk("sel_no_move", 32'(mv_a - m0), 0);

    // Simultaneous X and Y press
    press_btn(K_R | K_D, 40, 40);
    chk("xy_xa", 32'(xa), 1);
    chk("xy_ya", 32'(ya), 3);
    chk("xy_xb", 32'(xb), 5);
    chk("xy_yb", 32'(yb), 0);
    chk("xy_xc", 32'(xc), 0);
    chk("xy_yc", 32'(yc), 2);
    chk("xy_moves_a", 32'(mv_a - m0), 1);
    chk("xy_moves_b", 32'(mv_b - m1), 1);

    // Long hold: press at edge 19, repeats at +64,+80,+96,+112 when enabled
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_xa", 32'(xa), 0);
    chk("rst2_yb", 32'(yb), 0);
    press_btn(K_R, 120, 40);
`ifdef AUTO_REPEAT_EN
    chk("hold_xa", 32'(xa), 5);
    chk("hold_xb", 32'(xb), 5);
    chk("hold_xc", 32'(xc), 0);
`else
    chk("hold_xa", 32'(xa), 1);
    chk("hold_xb", 32'(xb), 1);
    chk("hold_xc", 32'(xc), 1);
`endif

    // Reset in the middle of a hold, then re-acceptance
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    btns = K_R;
    repeat (30) @(negedge clk);
    chk("midhold_x", 32'(xa), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_x", 32'(xa), 0);
    chk("midrst_db", 32'(dba), 0);
    repeat (18) @(negedge clk);
    chk("rearm_before", 32'(xa), 0);
    @(negedge clk);
    chk("rearm_after", 32'(xa), 1);
    btns = '0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
